// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit: FSM states,
// slice width and the saturation constants derived from the operand width.
package nibble_serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W  = 4;
    localparam int ALU_WIDTH = 16;
    localparam int MAX_W     = 64;

    // Largest positive two's-complement value of width w (0x7F..F).
    function automatic logic [MAX_W-1:0] max_pos(input int w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    // Most negative two's-complement value of width w (0x80..0).
    function automatic logic [MAX_W-1:0] min_neg(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Request/result bundle between the ALU sequencer (master) and the add/sub unit (slave).
// Handshake: start is a request the slave samples only while not busy; the
// operands are captured on that edge. done is a one-cycle strobe marking
// result/ovfl/zero/neg valid; they then hold until the next operation completes.
interface nibble_serial_addsub_if
    import nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovfl;
    logic             zero;
    logic             neg;

    modport master (
        output start, A, B, sub,
        input  busy, done, result, ovfl, zero, neg
    );

    modport slave (
        input  start, A, B, sub,
        output busy, done, result, ovfl, zero, neg
    );

endinterface

// File: rtl/nibble_serial_addsub_nibble_adder_cin.sv
// 4-bit ripple adder with explicit carry-in; also reports the carry into bit 3
// so the parent can derive signed overflow on the most significant nibble.
module nibble_adder_cin
    import nibble_serial_addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                cout_o,
    output logic                c3_o
);

    always_comb begin
        logic carry;
        carry = cin_i;
        s_o   = '0;
        c3_o  = 1'b0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            if (i == NIBBLE_W - 1) c3_o = carry;
            s_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle add/subtract: one 4-bit slice walks the latched operands LSB
// nibble first, then reports result and flags on a one-cycle done strobe.
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter bit SAT   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    nibble_serial_addsub_if.slave   bus,
    output state_e                  state_o
);

    localparam int NIBS  = WIDTH / NIBBLE_W;
    localparam int IDX_W = $clog2(NIBS);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NIBS - 1);
    localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(min_neg(WIDTH));

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q, acc_q, result_q;
    logic               sub_q, carry_q, busy_q, done_q, ovfl_q, zero_q, neg_q;
    logic [IDX_W-1:0]   idx_q;

    logic [NIBBLE_W-1:0] a_nib, b_nib, sum;
    logic                cout, c3;
    logic [WIDTH-1:0]    acc_d, result_d;
    logic                ovfl_d;

    assign a_nib = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[idx_q*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};

    nibble_adder_cin u_slice (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .cin_i  (carry_q),
        .s_o    (sum),
        .cout_o (cout),
        .c3_o   (c3)
    );

    // Each new nibble enters at the top; after NIBS shifts nibble 0 sits at the bottom.
    assign acc_d    = {sum, acc_q[WIDTH-1:NIBBLE_W]};
    assign ovfl_d   = cout ^ c3;
    assign result_d = (SAT && ovfl_d) ? (a_q[WIDTH-1] ? MIN_NEG : MAX_POS) : acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ovfl_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        sub_q   <= bus.sub;
                        carry_q <= bus.sub;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    carry_q <= cout;
                    idx_q   <= idx_q + 1'b1;
                    acc_q   <= acc_d;
                    if (idx_q == LAST) begin
                        result_q <= result_d;
                        ovfl_q   <= ovfl_d;
                        zero_q   <= (result_d == '0);
                        neg_q    <= result_d[WIDTH-1];
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.ovfl   = ovfl_q;
    assign bus.zero   = zero_q;
    assign bus.neg    = neg_q;
    assign state_o    = state_q;

endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Multi-cycle WIDTH-bit add/subtract unit that walks the operands one 4-bit nibble per cycle through a single carry-chained 4-bit slice. It sits in the ALU datapath where the CPU trades area for latency. Typical uses are the 16-bit ADD/SUB and saturating-arithmetic paths. It accepts an operation on a start pulse, iterates LSB nibble first, and reports the result with two's-complement overflow, zero and negative flags on a one-cycle done strobe.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8
- SAT, 1, 1 = saturate on signed overflow, 0 = wrap
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when not busy
- A  in  WIDTH  operand A, two's complement
- B  in  WIDTH  operand B, two's complement
- sub  in  1  0 = A+B, 1 = A−B
- busy  out  1  operation in progress
- done  out  1  one-cycle strobe, result/flags valid
- result  out  WIDTH  sum/difference (saturated if SAT)
- ovfl  out  1  raw signed overflow of the operation
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE or DONE, start=1:**
  - latch A, B, sub
  - nibble index ← 0, carry ← sub
  - go to RUN
- **IDLE or DONE, start=0:** go to IDLE. DONE lasts exactly one cycle.
- **RUN, each cycle:** slice computes nibble i = A[i] + (B[i] ^ {4{sub}}) + carry.
  - result nibble i ← slice sum
  - carry ← slice cout
  - index increments
- **RUN, last nibble (index = WIDTH/4−1):**
  - ovfl ← cout ^ carry-into-MSB
  - apply saturation
  - go to DONE
- **start while RUN:** ignored. Latched operands are unaffected. Input changes during RUN have no effect.
- **Saturation (SAT=1, ovfl=1):**
  - result = 0x7FFF…F if the latched A is non-negative
  - otherwise 0x800…0
- **SAT=0:** result wraps.
- **Flags:**
  - zero and neg are computed on the final (post-saturation) result
  - ovfl always reports the raw overflow, even when saturated
- **Output hold:** result, ovfl, zero and neg hold their values from DONE until the next accepted start completes. They are not cleared on accept.
- **Reset:** asynchronous at any time, including mid-RUN.
  - state → IDLE
  - busy=0, done=0
  - result=0, ovfl=0, zero=0, neg=0
  - internal carry/index/operands cleared
  - the aborted operation produces no done

## Timing
- Start is accepted at edge E0 when state is IDLE or DONE.
- busy=1 from after E0 through the last RUN cycle.
- busy=0 in the DONE cycle.
- RUN lasts exactly WIDTH/4 cycles (4 for WIDTH=16).
- done=1 for one cycle, WIDTH/4+1 edges after E0 (5 for WIDTH=16).
- result and flags are valid from the done cycle onward.
- Back-to-back: start held high in the DONE cycle is accepted, giving 1 op per WIDTH/4+1 cycles.
- busy and done are never high together.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- **Shared ALU package:**
  - state enum (IDLE/RUN/DONE)
  - NIBBLE_W = 4
  - saturation constants derived from WIDTH (MAX_POS, MIN_NEG)
- **Sub-module nibble_adder_cin:**
  - 4-bit ripple adder with explicit Cin
  - outputs S[3:0], Cout and C3 (carry into bit 3)
  - the slice's B-inversion is done by the parent
  - one instance

## Test plan
- **Plain add:** 0x1234 + 0x0FFF, sub=0 → 0x2233, ovfl=0, zero=0, neg=0. done exactly 5 cycles after the accepting edge; busy high 4 cycles.
- **Positive overflow:** 0x7FFF + 0x0001.
  - SAT=1 → result 0x7FFF, ovfl=1, neg=0
  - SAT=0 → result 0x8000, ovfl=1, neg=1
- **Negative overflow:** 0x8000 − 0x0001, SAT=1 → result 0x8000, ovfl=1, neg=1. Also 0xFFFF − 0x0001 → 0xFFFE, ovfl=0.
- **Zero result:** 0x0005 − 0x0005 → 0x0000, zero=1, ovfl=0.
- **Handshake:**
  - start pulsed with 0x0001+0x0001 during RUN of 0x0010+0x0020 → ignored; result 0x0030
  - start held in the DONE cycle → second op accepted immediately; done again 5 cycles later
- **Reset mid-op:** rst asserted in 2nd RUN cycle of 0x1111+0x2222 → all outputs 0 asynchronously, no done. A following 0x0003+0x0004 → 0x0007.
